// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending controller and the drink/coin output stage.
interface change_dispenser_if #(
    parameter int unsigned SALES_W = 8
);
    logic               drink;
    logic [1:0]         back;
    logic               vend_req;
    logic               vend_ack;
    logic               coin_req;
    logic               coin_ack;
    logic               busy;
    logic [SALES_W-1:0] sold;
    logic               overflow;

    modport master (
        output drink, back, vend_ack, coin_ack,
        input  vend_req, coin_req, busy, sold, overflow
    );

    modport slave (
        input  drink, back, vend_ack, coin_ack,
        output vend_req, coin_req, busy, sold, overflow
    );
endinterface

// File: rtl/change_dispenser.sv
// Queues paid drinks and half-yuan change, then releases them one unit per ack.
module change_dispenser #(
    parameter int unsigned DQ_W    = 2,
    parameter int unsigned CHG_W   = 4,
    parameter int unsigned SALES_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    change_dispenser_if.slave bus
);
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    state_t             state;
    logic [DQ_W-1:0]    dq;
    logic [CHG_W-1:0]   chg;
    logic [SALES_W-1:0] sold;
    logic               overflow;

    logic               vend_take;
    logic               coin_take;
    logic [DQ_W:0]      dq_sum;
    logic [CHG_W:0]     chg_sum;
    logic [DQ_W-1:0]    dq_next;
    logic [CHG_W-1:0]   chg_next;
    logic               dq_ovf;
    logic               chg_ovf;

    assign bus.vend_req = (state == VEND);
    assign bus.coin_req = (state == CHANGE);
    assign bus.busy     = (state != IDLE) || (dq != '0) || (chg != '0);
    assign bus.sold     = sold;
    assign bus.overflow = overflow;

    assign vend_take = (state == VEND) && bus.vend_ack;
    assign coin_take = (state == CHANGE) && bus.coin_ack;

    // Net update with a guard bit; a request is only up while its counter is
    // nonzero, so the guard bit can only mean "above maximum".
    always_comb begin
        dq_sum   = {1'b0, dq} + (DQ_W+1)'(bus.drink) - (DQ_W+1)'(vend_take);
        chg_sum  = {1'b0, chg} + (CHG_W+1)'(bus.back) - (CHG_W+1)'(coin_take);
        dq_ovf   = dq_sum[DQ_W];
        chg_ovf  = chg_sum[CHG_W];
        dq_next  = dq_ovf ? '1 : dq_sum[DQ_W-1:0];
        chg_next = chg_ovf ? '1 : chg_sum[CHG_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            dq       <= '0;
            chg      <= '0;
            sold     <= '0;
            overflow <= 1'b0;
        end else begin
            dq   <= dq_next;
            chg  <= chg_next;
            sold <= sold + SALES_W'(vend_take);
            if (dq_ovf || chg_ovf)
                overflow <= 1'b1;

            // IDLE looks at the registered counters, so a new unit costs one
            // extra cycle before its request rises.
            unique case (state)
                IDLE: begin
                    if (dq != '0)
                        state <= VEND;
                    else if (chg != '0)
                        state <= CHANGE;
                end
                VEND: begin
                    if (dq_next == '0)
                        state <= (chg_next != '0) ? CHANGE : IDLE;
                end
                CHANGE: begin
                    if (chg_next == '0)
                        state <= (dq_next != '0) ? VEND : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Directed test-plan scenarios plus random traffic checked against a counting model.
module tb_change_dispenser;
    localparam int unsigned DQ_W    = 2;
    localparam int unsigned CHG_W   = 4;
    localparam int unsigned SALES_W = 8;
    localparam int DQ_MAX   = 3;
    localparam int CHG_MAX  = 15;
    localparam int SOLD_MOD = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    change_dispenser_if #(.SALES_W(SALES_W)) bus ();

    change_dispenser #(
        .DQ_W   (DQ_W),
        .CHG_W  (CHG_W),
        .SALES_W(SALES_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Model: pending counts plus what the output stage is currently serving.
    int m_dq, m_chg, m_sold, m_mode;  // mode: 0 nothing, 1 drinks, 2 change
    bit m_ovf, m_valid;

    int errors = 0;
    int checks = 0;
    logic last_vend, last_coin;
    int coin_acks, vend_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit d, input int b, input bit va, input bit ca);
        int nd, nc, vt, ct;
        @(negedge clk);
        reset        = r;
        bus.drink    = d;
        bus.back     = b[1:0];
        bus.vend_ack = va;
        bus.coin_ack = ca;
        last_vend = bus.vend_req;
        last_coin = bus.coin_req;
        if (last_coin === 1'b1 && ca && !r) coin_acks++;
        if (last_vend === 1'b1) vend_seen++;
        if (m_valid) begin
            check_val("vend_req", 32'(bus.vend_req), 32'(m_mode == 1));
            check_val("coin_req", 32'(bus.coin_req), 32'(m_mode == 2));
            check_val("busy", 32'(bus.busy), 32'(m_mode != 0 || m_dq != 0 || m_chg != 0));
            check_val("sold", 32'(bus.sold), 32'(m_sold));
            check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
        @(posedge clk);
        if (r) begin
            m_dq = 0; m_chg = 0; m_sold = 0; m_mode = 0; m_ovf = 0; m_valid = 1;
        end else begin
            vt = (m_mode == 1 && va) ? 1 : 0;
            ct = (m_mode == 2 && ca) ? 1 : 0;
            nd = m_dq + int'(d) - vt;
            nc = m_chg + b - ct;
            if (nd > DQ_MAX) begin nd = DQ_MAX; m_ovf = 1; end
            if (nc > CHG_MAX) begin nc = CHG_MAX; m_ovf = 1; end
            m_sold = (m_sold + vt) % SOLD_MOD;
            case (m_mode)
                0: m_mode = (m_dq != 0) ? 1 : (m_chg != 0) ? 2 : 0;
                1: if (nd == 0) m_mode = (nc != 0) ? 2 : 0;
                default: if (nc == 0) m_mode = (nd != 0) ? 1 : 0;
            endcase
            m_dq = nd;
            m_chg = nc;
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        coin_acks = 0;
        vend_seen = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_mode != 0 || m_dq != 0 || m_chg != 0) && n < 100) begin
            step(0, 0, 0, 1, 1);
            n++;
        end
        check_val("drain_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.drink = 1'b0; bus.back = 2'd0; bus.vend_ack = 1'b0; bus.coin_ack = 1'b0;
        m_valid = 0; m_dq = 0; m_chg = 0; m_sold = 0; m_mode = 0; m_ovf = 0;

        // Reset state and drink+change with both acks held high.
        do_reset();
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_sold", 32'(bus.sold), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step(0, k == 0, (k == 0) ? 2 : 0, 1, 1);
            check_val("s1_vend", 32'(last_vend), 32'(k == 2));
            check_val("s1_coin", 32'(last_coin), 32'(k == 3 || k == 4));
        end
        #1;
        check_val("s1_sold", 32'(bus.sold), 32'd1);
        check_val("s1_busy", 32'(bus.busy), 32'd0);

        // Change of 3 with the hopper stalled for five cycles.
        do_reset();
        step(0, 0, 3, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1);
        check_val("s2_acks", 32'(coin_acks), 32'd3);
        check_val("s2_novend", 32'(vend_seen), 32'd0);
        check_val("s2_idle", 32'(bus.busy), 32'd0);

        // Drink arriving in the same cycle as a coin ack.
        do_reset();
        step(0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        check_val("s3_coin_up", 32'(last_coin), 32'd1);
        #1;
        check_val("s3_chg", 32'(dut.chg), 32'd1);
        check_val("s3_dq", 32'(dut.dq), 32'd1);
        step(0, 0, 0, 1, 1);
        check_val("s3_coin2", 32'(last_coin), 32'd1);
        step(0, 0, 0, 1, 1);
        check_val("s3_vend", 32'(last_vend), 32'd1);
        drain();

        // Drink queue saturation.
        do_reset();
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        #1;
        check_val("s4_dq_sat", 32'(dut.dq), 32'd3);
        check_val("s4_ovf", 32'(bus.overflow), 32'd1);
        drain();
        #1;
        check_val("s4_sold", 32'(bus.sold), 32'd3);
        check_val("s4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset in the middle of a vend.
        do_reset();
        step(0, 1, 3, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_val("s5_in_vend", 32'(last_vend), 32'd1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check_val("s5_vend_low", 32'(last_vend), 32'd0);
        check_val("s5_coin_low", 32'(last_coin), 32'd0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 1);
        #1;
        check_val("s5_sold", 32'(bus.sold), 32'd0);
        check_val("s5_busy", 32'(bus.busy), 32'd0);

        // 256 sales wrap the counter without overflow.
        do_reset();
        for (int k = 0; k < 256; k++) step(0, 1, 0, 1, 0);
        drain();
        #1;
        check_val("s6_wrap", 32'(bus.sold), 32'd0);
        check_val("s6_no_ovf", 32'(bus.overflow), 32'd0);

        // Random traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 150) == 0, ($urandom % 4) == 0,
                 (($urandom % 3) == 0) ? int'($urandom % 4) : 0,
                 ($urandom % 2) == 0, ($urandom % 2) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
